pixel_unpacker: RTL
===================

PIXEL_UNPACKER -- requirements
Module: pixel_unpacker

Interface
REQ-001 The block SHALL have parameter WORD_W, default 16, meaning the input word width in pixels (1 bit per pixel), range 2..32.
REQ-002 The block SHALL have parameter DEPTH, default 4, meaning the word FIFO depth, a power of two from 2 to 16.
REQ-003 The block SHALL have port clk_25mhz  input  1  pixel clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 The block SHALL have port wr_data  input  WORD_W  packed monochrome pixel word.
REQ-006 The block SHALL have port wr_sof  input  1  marks the word as carrying pixel (0,0) of a frame.
REQ-007 The block SHALL have port wr_valid  input  1  word offered by the upstream producer.
REQ-008 The block SHALL have port wr_ready  output  1  word accepted on an edge where wr_valid and wr_ready are both high.
REQ-009 The block SHALL have port flush  input  1  synchronous discard of all buffered pixels.
REQ-010 The block SHALL have port fifo_read  input  1  pixel pop request from the timing generator.
REQ-011 The block SHALL have port pix_data  output  1  current pixel bit.
REQ-012 The block SHALL have port pix_empty  output  1  no pixel available.
REQ-013 The block SHALL have port pix_sof  output  1  current pixel is pixel (0,0); drives the timing generator's zero_zero.
REQ-014 The block SHALL have port level  output  clog2(DEPTH)+1  number of words in the FIFO, excluding the word being shifted.

Function
REQ-015 The FIFO SHALL store {wr_sof, wr_data} per entry, in circular order, with read/write pointers wrapping modulo DEPTH.
REQ-016 wr_ready SHALL equal (level < DEPTH) and not flush; a write SHALL NOT be accepted when full, even with a same-cycle FIFO pop.
REQ-017 An output stage SHALL hold one word in a shift register, a bit index 0..WORD_W-1, the word's sof flag, and a loaded flag.
REQ-018 pix_data SHALL be the register MSB (MSB-first order); pix_empty SHALL be not loaded; pix_sof SHALL be loaded AND sof flag AND bit index = 0.
REQ-019 When loaded is low and the FIFO is non-empty, the stage SHALL pop one word and set loaded on the next edge.
REQ-020 A word accepted on edge N SHALL give pix_empty low after edge N+1 when the stage and FIFO were empty.
REQ-021 fifo_read while loaded SHALL shift the register left one bit and increment the bit index.
REQ-022 fifo_read at bit index WORD_W-1 SHALL reload from the FIFO on the same edge when the FIFO is non-empty (no bubble); otherwise it SHALL clear loaded.
REQ-023 fifo_read while pix_empty is high SHALL be ignored and leave all state unchanged.
REQ-024 flush SHALL clear pointers, level, loaded, and bit index on the next edge; flush SHALL win over a same-cycle write or read.
REQ-025 A sustained fifo_read at one pop per clock SHALL be sustainable indefinitely when at least one word is accepted every WORD_W cycles.

Reset
REQ-026 rst SHALL asynchronously clear pointers, level, loaded, bit index, shift register, and sof flag.
REQ-027 During and after reset: wr_ready=1, pix_empty=1, pix_data=0, pix_sof=0, level=0; reset mid-word SHALL drop the partial word.

Configuration
REQ-028 Macro PIXEL_UNPACKER_UNDERFLOW_CNT_EN SHALL, when defined, add output underflow_cnt (16 bits). underflow_cnt SHALL reset to 0 and increment, saturating at 16'hFFFF, on each edge with fifo_read=1 and pix_empty=1. flush SHALL clear underflow_cnt.
REQ-029 Without PIXEL_UNPACKER_UNDERFLOW_CNT_EN, the port and counter SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-030 Reset, then write 16'hA5C3 with sof=1, then hold fifo_read=1 -> pix_empty low one cycle after the accept; pix_sof=1 on the first bit only; pix_data sequence is 1010010111000011.
REQ-031 Write 5 words with fifo_read=0 (DEPTH=4) -> 1 word goes to the output stage and 4 to the FIFO; level=4, wr_ready=0; the 6th write stalls until bit 15 of the first word is popped.
REQ-032 Write 16'hFFFF then 16'h0000 back-to-back and pop continuously -> 32 consecutive valid bits (16 ones then 16 zeros) with pix_empty never high between words.
REQ-033 fifo_read=1 for 3 cycles with no data (macro defined) -> state unchanged, underflow_cnt=3; assert flush -> underflow_cnt=0.
REQ-034 Assert flush at bit index 7 while wr_valid=1 and level=2 -> the write is not accepted; after the edge: level=0, pix_empty=1, pix_sof=0.
REQ-035 Assert rst asynchronously mid-word -> outputs go to reset values before the next clock edge; the next written word starts at bit 15 (MSB).

Source files
------------

// File: rtl/pixel_unpacker.sv
// Packed monochrome word FIFO feeding an MSB-first pixel shifter for a timing generator.
// Optional underflow counter port enabled by defining PIXEL_UNPACKER_UNDERFLOW_CNT_EN.
module pixel_unpacker #(
    parameter int WORD_W = 16,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_25mhz,
    input  logic                     rst,
    input  logic [WORD_W-1:0]        wr_data,
    input  logic                     wr_sof,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic                     flush,
    input  logic                     fifo_read,
    output logic                     pix_data,
    output logic                     pix_empty,
    output logic                     pix_sof,
`ifdef PIXEL_UNPACKER_UNDERFLOW_CNT_EN
    output logic [15:0]              underflow_cnt,
`endif
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int IW = $clog2(WORD_W);

    logic [WORD_W:0]   mem [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [WORD_W-1:0] shreg_r;
    logic [IW-1:0]     bit_idx_r;
    logic              sof_r;
    logic              loaded_r;

    logic              fifo_nonempty_s;
    logic              last_bit_s;
    logic              read_s;
    logic              pop_s;
    logic              wr_ready_s;
    logic              wr_fire_s;
    logic [WORD_W:0]   head_s;

    // Handshake and pop decisions; a reload at the last bit keeps the pixel stream bubble-free.
    always_comb begin
        fifo_nonempty_s = (level_r != {LW{1'b0}});
        last_bit_s      = (bit_idx_r == IW'(WORD_W - 1));
        read_s          = fifo_read && loaded_r;
        pop_s           = fifo_nonempty_s && (!loaded_r || (read_s && last_bit_s));
        wr_ready_s      = (level_r < LW'(DEPTH)) && !flush;
        wr_fire_s       = wr_valid && wr_ready_s;
        head_s          = mem[rd_ptr_r];
    end

    // Entry storage; contents need no reset since level gates every read.
    always_ff @(posedge clk_25mhz) begin
        if (wr_fire_s) begin
            mem[wr_ptr_r] <= {wr_sof, wr_data};
        end else begin
            mem[wr_ptr_r] <= mem[wr_ptr_r];
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
        end else begin
            if (wr_fire_s) begin
                wr_ptr_r <= wr_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            level_r <= level_r + {{AW{1'b0}}, wr_fire_s} - {{AW{1'b0}}, pop_s};
        end
    end

    // Output shift stage.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            shreg_r   <= {WORD_W{1'b0}};
            bit_idx_r <= {IW{1'b0}};
            sof_r     <= 1'b0;
            loaded_r  <= 1'b0;
        end else if (flush) begin
            bit_idx_r <= {IW{1'b0}};
            loaded_r  <= 1'b0;
        end else if (pop_s) begin
            shreg_r   <= head_s[WORD_W-1:0];
            sof_r     <= head_s[WORD_W];
            bit_idx_r <= {IW{1'b0}};
            loaded_r  <= 1'b1;
        end else if (read_s) begin
            if (last_bit_s) begin
                bit_idx_r <= {IW{1'b0}};
                loaded_r  <= 1'b0;
            end else begin
                shreg_r   <= {shreg_r[WORD_W-2:0], 1'b0};
                bit_idx_r <= bit_idx_r + {{(IW-1){1'b0}}, 1'b1};
            end
        end else begin
            loaded_r <= loaded_r;
        end
    end

`ifdef PIXEL_UNPACKER_UNDERFLOW_CNT_EN
    logic [15:0] underflow_cnt_r;

    // Counts pops requested while no pixel is available, saturating.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            underflow_cnt_r <= 16'h0000;
        end else if (flush) begin
            underflow_cnt_r <= 16'h0000;
        end else if (fifo_read && !loaded_r && (underflow_cnt_r != 16'hFFFF)) begin
            underflow_cnt_r <= underflow_cnt_r + 16'h0001;
        end else begin
            underflow_cnt_r <= underflow_cnt_r;
        end
    end

    assign underflow_cnt = underflow_cnt_r;
`endif

    assign wr_ready  = wr_ready_s;
    assign pix_data  = shreg_r[WORD_W-1];
    assign pix_empty = !loaded_r;
    assign pix_sof   = loaded_r && sof_r && (bit_idx_r == {IW{1'b0}});
    assign level     = level_r;

endmodule
